// File: rtl/acc_store_queue.sv
// Accumulator store queue: circular FIFO of {addr,data} writes drained to memory
// through a req/ack handshake, with a sticky overflow flag for dropped stores.
module acc_store_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       store,
   input  logic [AW-1:0]              st_addr,
   input  logic [7:0]                 st_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       mem_req,
   output logic [AW-1:0]              mem_addr,
   output logic [7:0]                 mem_wdata,
   input  logic                       mem_ack
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [7:0]    data_mem [DEPTH];

   logic [AW-1:0] head_addr_q, head_addr_d;
   logic [7:0]    head_data_q, head_data_d;

   logic push, pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign mem_req   = ~empty;
   assign mem_addr  = head_addr_q;
   assign mem_wdata = head_data_q;

   assign push = store & ~full;
   assign pop  = mem_req & mem_ack;

   always_comb begin
      wr_d        = wr_q;
      rd_d        = rd_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (store & full);
      head_addr_d = head_addr_q;
      head_data_d = head_data_q;

      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Output registers track the next head; when the queue goes empty they hold.
      // If the next head is the slot being written this cycle, take it from the inputs.
      if (count_d != '0) begin
         if (push && (rd_d == wr_q)) begin
            head_addr_d = st_addr;
            head_data_d = st_data;
         end else begin
            head_addr_d = addr_mem[rd_d];
            head_data_d = data_mem[rd_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage and head registers carry no reset; their content is qualified by count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_q] <= st_addr;
         data_mem[wr_q] <= st_data;
      end
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
   end

endmodule

// File: tb/tb_acc_store_queue.sv
// Self-checking bench for acc_store_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_acc_store_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          store;
   logic [AW-1:0] st_addr;
   logic [7:0]    st_data;
   logic          full;
   logic          empty;
   logic [2:0]    count;
   logic          overflow;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_ack;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: FIFO of {addr,data}, sticky overflow, last issued head.
   logic [15:0] model_q [$];
   bit          model_ovf;
   logic [15:0] model_last;
   bit          model_last_ok;

   always #5 clk = ~clk;

   acc_store_queue #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .store     (store),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic s, input logic [7:0] a,
                               input logic [7:0] d, input logic k);
      bit was_full;
      if (r) begin
         model_q.delete();
         model_ovf     = 1'b0;
         model_last_ok = 1'b0;
      end else begin
         was_full = (model_q.size() == DEPTH);
         if (s && was_full) model_ovf = 1'b1;
         if (k && model_q.size() > 0) void'(model_q.pop_front());
         if (s && !was_full) model_q.push_back({a, d});
      end
      if (model_q.size() > 0) begin
         model_last    = model_q[0];
         model_last_ok = 1'b1;
      end
   endtask

   task automatic model_compare();
      check("count", 32'(count), 32'(model_q.size()));
      check("empty", 32'(empty), 32'(model_q.size() == 0));
      check("full", 32'(full), 32'(model_q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(model_ovf));
      check("mem_req", 32'(mem_req), 32'(model_q.size() != 0));
      if (model_last_ok) begin
         check("mem_addr", 32'(mem_addr), 32'(model_last[15:8]));
         check("mem_wdata", 32'(mem_wdata), 32'(model_last[7:0]));
      end
   endtask

   // Apply one cycle of inputs, advance the model across the edge, then compare.
   task automatic step(input logic r, input logic s, input logic [7:0] a,
                       input logic [7:0] d, input logic k);
      rst     = r;
      store   = s;
      st_addr = a;
      st_data = d;
      mem_ack = k;
      @(posedge clk);
      model_update(r, s, a, d, k);
      #1;
      model_compare();
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      rst = 1'b1; store = 1'b0; st_addr = '0; st_data = '0; mem_ack = 1'b0;
      model_ovf = 1'b0; model_last_ok = 1'b0; model_last = '0;

      // Reset state
      do_reset();
      do_reset();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_req", 32'(mem_req), 32'd0);

      // Single store with ack held: issued next cycle for one cycle
      step(1'b0, 1'b1, 8'h10, 8'hA5, 1'b1);
      check("single_req", 32'(mem_req), 32'd1);
      check("single_addr", 32'(mem_addr), 32'h10);
      check("single_data", 32'(mem_wdata), 32'hA5);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      check("single_empty", 32'(empty), 32'd1);

      // Fill past capacity, then drain in order
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b1, 8'(i), 8'(i), 1'b0);
         if (i == 4) check("fill_full", 32'(full), 32'd1);
      end
      check("fill_ovf", 32'(overflow), 32'd1);
      check("fill_count", 32'(count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         check("drain_data", 32'(mem_wdata), 32'(i));
         step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      end
      check("drain_empty", 32'(empty), 32'd1);

      // Simultaneous push and pop at count=2
      do_reset();
      step(1'b0, 1'b1, 8'h21, 8'h11, 1'b0);
      step(1'b0, 1'b1, 8'h22, 8'h12, 1'b0);
      step(1'b0, 1'b1, 8'h23, 8'h13, 1'b1);
      check("pp_count", 32'(count), 32'd2);
      check("pp_head", 32'(mem_wdata), 32'h12);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      check("pp_last", 32'(mem_wdata), 32'h13);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

      // Store while full with a pop: dropped
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 8'(8'h50 + i), 1'b0);
      step(1'b0, 1'b1, 8'h99, 8'h99, 1'b1);
      check("drop_count", 32'(count), 32'd3);
      check("drop_ovf", 32'(overflow), 32'd1);

      // Pending entry held stable under back-pressure
      do_reset();
      step(1'b0, 1'b1, 8'h66, 8'h77, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
         check("hold_addr", 32'(mem_addr), 32'h66);
      end

      // Reset mid-operation discards entries
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(i), 8'(8'hC0 + i), 1'b0);
      do_reset();
      check("midrst_req", 32'(mem_req), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      step(1'b0, 1'b1, 8'h7E, 8'h7E, 1'b0);
      check("midrst_first", 32'(mem_wdata), 32'h7E);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(63) == 0), $urandom_range(1) == 1,
              8'($urandom), 8'($urandom), $urandom_range(2) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
